// File: rtl/hs_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : hs_output_stage
//  Description : Finishing stage for the hardswish segment. Pairs each raw
//                segment product with its original x (held in an alignment
//                queue), applies the clamp regions, rounds/saturates the
//                linear-region product down to the result format and buffers
//                results behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_output_stage #(
    parameter int DATA_WIDTH = 21,
    parameter int FRAC_BITS  = 7,
    parameter int PROD_WIDTH = 88,
    parameter int PROD_SHIFT = 21,
    parameter int XQ_DEPTH   = 4,
    parameter int OQ_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic                         x_en,
    input  logic signed [PROD_WIDTH-1:0] prod_in,
    input  logic                         prod_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         xq_overflow,
    output logic                         xq_underflow,
    output logic                         oq_overflow,
    output logic                         busy
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int XA  = $clog2(XQ_DEPTH);
    localparam int XCW = XA + 1;
    localparam int OA  = $clog2(OQ_DEPTH);
    localparam int OCW = OA + 1;
    // One guard bit above the product so the rounding add can never wrap.
    localparam int RW  = PROD_WIDTH + 1;

    localparam logic [XCW-1:0] C_XQ_FULL = XCW'(XQ_DEPTH);
    localparam logic [OCW-1:0] C_OQ_FULL = OCW'(OQ_DEPTH);

    // +/-3.0 in the input format: region boundaries of hardswish.
    localparam logic signed [DATA_WIDTH-1:0] C_POS3 = DATA_WIDTH'(3 <<< FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] C_NEG3 = -C_POS3;

    // Half an LSB of the result scale, expressed at product scale.
    localparam logic signed [RW-1:0] C_HALF =
        {{(RW-PROD_SHIFT){1'b0}}, 1'b1, {(PROD_SHIFT-1){1'b0}}};

    // Saturation limits of the result, sign-extended to the rounding width.
    localparam logic signed [RW-1:0] C_SAT_MAX =
        {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] C_SAT_MIN =
        {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] C_RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] C_RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        RG_LIN = 2'd0,
        RG_NEG = 2'd1,
        RG_POS = 2'd2
    } region_t;

    // ------------------------------------------------------------------------
    // X alignment queue
    // ------------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] r_xq_mem [XQ_DEPTH];
    logic        [XA-1:0]         r_xq_wr;
    logic        [XA-1:0]         r_xq_rd;
    logic        [XCW-1:0]        r_xq_count;

    logic                         w_xq_full;
    logic                         w_xq_empty;
    logic                         w_xq_pop;
    logic                         w_xq_push;
    logic signed [DATA_WIDTH-1:0] w_xq_head;

    assign w_xq_full  = (r_xq_count == C_XQ_FULL);
    assign w_xq_empty = (r_xq_count == '0);
    // A product only consumes an x that was already queued; no same-cycle bypass.
    assign w_xq_pop   = prod_valid & ~w_xq_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_xq_push  = x_en & (~w_xq_full | w_xq_pop);
    assign w_xq_head  = r_xq_mem[r_xq_rd];

    // Queue storage: data only, occupancy is tracked by pointers/count.
    always_ff @(posedge clk) begin
        if (w_xq_push) begin
            r_xq_mem[r_xq_wr] <= x_in;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xq_wr    <= '0;
            r_xq_rd    <= '0;
            r_xq_count <= '0;
        end else begin
            if (w_xq_push) begin
                r_xq_wr <= r_xq_wr + 1'b1;
            end
            if (w_xq_pop) begin
                r_xq_rd <= r_xq_rd + 1'b1;
            end
            case ({w_xq_push, w_xq_pop})
                2'b10:   r_xq_count <= r_xq_count + 1'b1;
                2'b01:   r_xq_count <= r_xq_count - 1'b1;
                default: r_xq_count <= r_xq_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stage A: region classification and round-half-up requantization
    // ------------------------------------------------------------------------
    region_t                      w_region;
    logic signed [RW-1:0]         w_prod_ext;
    logic signed [RW-1:0]         w_sum;
    logic signed [RW-1:0]         w_rnd;

    logic                         r_a_valid;
    region_t                      r_a_region;
    logic signed [DATA_WIDTH-1:0] r_a_x;
    logic signed [RW-1:0]         r_a_r;

    assign w_prod_ext = {prod_in[PROD_WIDTH-1], prod_in};
    assign w_sum      = w_prod_ext + C_HALF;
    assign w_rnd      = w_sum >>> PROD_SHIFT;

    // Classify the popped x into the hardswish clamp regions.
    always_comb begin
        w_region = RG_LIN;
        if (w_xq_head <= C_NEG3) begin
            w_region = RG_NEG;
        end else if (w_xq_head >= C_POS3) begin
            w_region = RG_POS;
        end
    end

    // Capture x, its region and the rounded product when a pair is formed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_valid  <= 1'b0;
            r_a_region <= RG_LIN;
            r_a_x      <= '0;
            r_a_r      <= '0;
        end else begin
            r_a_valid <= w_xq_pop;
            if (w_xq_pop) begin
                r_a_region <= w_region;
                r_a_x      <= w_xq_head;
                r_a_r      <= w_rnd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage B: select the final result (pushed into the output FIFO)
    // ------------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] w_lin_sat;
    logic signed [DATA_WIDTH-1:0] w_res;

    // Saturate the rounded linear-region value to the result range.
    always_comb begin
        w_lin_sat = r_a_r[DATA_WIDTH-1:0];
        if (r_a_r > C_SAT_MAX) begin
            w_lin_sat = C_RES_MAX;
        end else if (r_a_r < C_SAT_MIN) begin
            w_lin_sat = C_RES_MIN;
        end
    end

    // Region mux: below -3 the output is 0, above +3 it is x itself.
    always_comb begin
        w_res = w_lin_sat;
        case (r_a_region)
            RG_NEG:  w_res = '0;
            RG_POS:  w_res = r_a_x;
            default: w_res = w_lin_sat;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] r_oq_mem [OQ_DEPTH];
    logic        [OA-1:0]         r_oq_wr;
    logic        [OA-1:0]         r_oq_rd;
    logic        [OCW-1:0]        r_oq_count;

    logic                         w_oq_full;
    logic                         w_oq_pop;
    logic                         w_oq_push;

    assign out_valid = (r_oq_count != '0);
    assign out_data  = out_valid ? r_oq_mem[r_oq_rd] : '0;
    assign w_oq_full = (r_oq_count == C_OQ_FULL);
    assign w_oq_pop  = out_valid & out_ready;
    // The segment cannot stall, so a result with nowhere to go is dropped.
    assign w_oq_push = r_a_valid & (~w_oq_full | w_oq_pop);

    // FIFO storage: written only when a result is accepted.
    always_ff @(posedge clk) begin
        if (w_oq_push) begin
            r_oq_mem[r_oq_wr] <= w_res;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oq_wr    <= '0;
            r_oq_rd    <= '0;
            r_oq_count <= '0;
        end else begin
            if (w_oq_push) begin
                r_oq_wr <= r_oq_wr + 1'b1;
            end
            if (w_oq_pop) begin
                r_oq_rd <= r_oq_rd + 1'b1;
            end
            case ({w_oq_push, w_oq_pop})
                2'b10:   r_oq_count <= r_oq_count + 1'b1;
                2'b01:   r_oq_count <= r_oq_count - 1'b1;
                default: r_oq_count <= r_oq_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags and activity indication
    // ------------------------------------------------------------------------
    logic r_xq_overflow;
    logic r_xq_underflow;
    logic r_oq_overflow;

    // Flags latch on the first fault and clear only through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xq_overflow  <= 1'b0;
            r_xq_underflow <= 1'b0;
            r_oq_overflow  <= 1'b0;
        end else begin
            if (x_en && w_xq_full && !w_xq_pop) begin
                r_xq_overflow <= 1'b1;
            end
            if (prod_valid && w_xq_empty) begin
                r_xq_underflow <= 1'b1;
            end
            if (r_a_valid && w_oq_full && !w_oq_pop) begin
                r_oq_overflow <= 1'b1;
            end
        end
    end

    assign xq_overflow  = r_xq_overflow;
    assign xq_underflow = r_xq_underflow;
    assign oq_overflow  = r_oq_overflow;
    // Stage B is the combinational push of stage A's result, so stage A
    // valid covers both pipeline stages.
    assign busy         = (r_xq_count != '0) | r_a_valid | (r_oq_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_hs_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hs_output_stage
//  Description : Self-checking bench for hs_output_stage. A queue-based
//                behavioural model predicts outputs every cycle; directed
//                tests add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_output_stage;

    localparam int DW = 21;
    localparam int PW = 88;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] x_in;
    logic                 x_en;
    logic signed [PW-1:0] prod_in;
    logic                 prod_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 xq_overflow;
    logic                 xq_underflow;
    logic                 oq_overflow;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    hs_output_stage dut (
        .clk          (clk),
        .rst          (rst),
        .x_in         (x_in),
        .x_en         (x_en),
        .prod_in      (prod_in),
        .prod_valid   (prod_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .xq_overflow  (xq_overflow),
        .xq_underflow (xq_underflow),
        .oq_overflow  (oq_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Hardswish result from x and the raw product, straight from the rules.
    function automatic int hs_ref(input int x, input logic signed [127:0] p);
        logic signed [127:0] r;
        if (x <= -384) return 0;
        if (x >= 384) return x;
        r = (p + 128'sd1048576) >>> 21;
        if (r > 128'sd1048575) return 1048575;
        if (r < -128'sd1048576) return -1048576;
        return int'(r);
    endfunction

    // Product the segment would deliver for x.
    function automatic logic signed [127:0] prodf(input int x);
        logic signed [127:0] a;
        logic signed [127:0] b;
        a = x + 384;
        a = a * 21;
        b = x;
        b = b * 128;
        return a * b;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: x queue, one-cycle pairing stage, bounded result queue
    // ------------------------------------------------------------------------
    int  mx_q[$];
    int  mo_q[$];
    bit  ma_valid;
    int  ma_val;
    bit  m_xov, m_xun, m_oov;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx_q.delete();
            mo_q.delete();
            ma_valid = 1'b0;
            ma_val   = 0;
            m_xov    = 1'b0;
            m_xun    = 1'b0;
            m_oov    = 1'b0;
        end else begin
            int xs;
            bit popx;
            logic signed [127:0] pe;
            xs = mx_q.size();
            if (mo_q.size() != 0 && out_ready) void'(mo_q.pop_front());
            if (ma_valid) begin
                if (mo_q.size() < 4) mo_q.push_back(ma_val);
                else m_oov = 1'b1;
            end
            popx     = prod_valid && (xs != 0);
            ma_valid = popx;
            if (popx) begin
                pe     = prod_in;
                ma_val = hs_ref(mx_q.pop_front(), pe);
            end
            if (prod_valid && xs == 0) m_xun = 1'b1;
            if (x_en) begin
                if (mx_q.size() < 4) mx_q.push_back(int'(x_in));
                else m_xov = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", longint'(out_valid), longint'(mo_q.size() != 0));
        chk("out_data", longint'(out_data), (mo_q.size() != 0) ? longint'(mo_q[0]) : 64'sd0);
        chk("xq_overflow", longint'(xq_overflow), longint'(m_xov));
        chk("xq_underflow", longint'(xq_underflow), longint'(m_xun));
        chk("oq_overflow", longint'(oq_overflow), longint'(m_oov));
        chk("busy", longint'(busy), longint'(mx_q.size() != 0 || ma_valid || mo_q.size() != 0));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic cyc(input bit xe, input int xv, input bit pv,
                       input logic signed [127:0] pd, input bit rdy);
        x_en       = xe;
        x_in       = xv[DW-1:0];
        prod_valid = pv;
        prod_in    = pd[PW-1:0];
        out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 0, 1'b0, 128'sd0, rdy);
    endtask

    task automatic one_sample(input int x, input logic signed [127:0] p,
                              input int exp, input string nm);
        cyc(1'b1, x, 1'b0, 128'sd0, 1'b1);
        cyc(1'b0, 0, 1'b1, p, 1'b1);
        chk({nm, "_lat_early"}, longint'(out_valid), 0);
        idle(1'b1);
        chk({nm, "_valid"}, longint'(out_valid), 1);
        chk({nm, "_data"}, longint'(out_data), longint'(exp));
        idle(1'b1);
    endtask

    // Asserted just after an edge; released before the next one.
    task automatic do_reset(input string nm);
        rst = 1'b0;
        #1;
        chk({nm, "_out_valid"}, longint'(out_valid), 0);
        chk({nm, "_out_data"}, longint'(out_data), 0);
        chk({nm, "_flags"}, longint'({xq_overflow, xq_underflow, oq_overflow}), 0);
        chk({nm, "_busy"}, longint'(busy), 0);
        #1;
        rst = 1'b1;
    endtask

    int xs8[8] = '{-500, -383, -200, 0, 64, 300, 384, 1000};
    int bx[6]  = '{128, -128, 640, -384, 383, 10};

    initial begin
        x_en       = 1'b0;
        x_in       = '0;
        prod_valid = 1'b0;
        prod_in    = '0;
        out_ready  = 1'b1;
        rst        = 1'b1;
        #1 rst     = 1'b0;
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_busy", longint'(busy), 0);
        #11 rst    = 1'b1;

        // Linear region, product three cycles after x.
        cyc(1'b1, 128, 1'b0, 128'sd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b0, 0, 1'b1, 128'sd176160768, 1'b1);
        chk("lin_pos_early", longint'(out_valid), 0);
        idle(1'b1);
        chk("lin_pos_valid", longint'(out_valid), 1);
        chk("lin_pos_data", longint'(out_data), 84);
        idle(1'b1);

        // Negative linear, clamp regions, rounding and saturation boundaries.
        one_sample(-128, -128'sd88080384, -42, "lin_neg");
        one_sample(-384, 128'sd12345, 0, "clamp_neg");
        one_sample(640, prodf(640), 640, "clamp_pos");
        one_sample(383, prodf(383), 377, "edge_383");
        one_sample(0, 128'sd3145728, 2, "half_pos");
        one_sample(0, -128'sd3145728, -1, "half_neg");
        one_sample(200, 128'sd1 << 60, 1048575, "sat_pos");
        one_sample(200, -(128'sd1 << 60), -1048576, "sat_neg");

        // Streaming: x leads its product by one cycle.
        cyc(1'b1, xs8[0], 1'b0, 128'sd0, 1'b1);
        for (int i = 1; i < 8; i++) cyc(1'b1, xs8[i], 1'b1, prodf(xs8[i-1]), 1'b1);
        cyc(1'b0, 0, 1'b1, prodf(xs8[7]), 1'b1);
        chk("stream_busy_t0", longint'(busy), 1);
        idle(1'b1);
        chk("stream_busy_t1", longint'(busy), 1);
        chk("stream_last", longint'(out_data), 1000);
        idle(1'b1);
        chk("stream_busy_t2", longint'(busy), 0);
        chk("stream_flags", longint'({xq_overflow, xq_underflow, oq_overflow}), 0);

        // Backpressure: six results into a four-deep FIFO.
        cyc(1'b1, bx[0], 1'b0, 128'sd0, 1'b0);
        for (int i = 1; i < 6; i++) cyc(1'b1, bx[i], 1'b1, prodf(bx[i-1]), 1'b0);
        cyc(1'b0, 0, 1'b1, prodf(bx[5]), 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("bp_oq_overflow", longint'(oq_overflow), 1);
        chk("bp_head", longint'(out_data), 84);
        begin
            int n;
            n = 0;
            for (int i = 0; i < 10; i++) begin
                if (out_valid) n++;
                idle(1'b1);
            end
            chk("bp_drain_count", longint'(n), 4);
        end

        // Queue faults.
        do_reset("rst1");
        cyc(1'b0, 0, 1'b1, prodf(5), 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("underflow_flag", longint'(xq_underflow), 1);
        chk("underflow_noout", longint'(out_valid), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 10 * i + 1, 1'b0, 128'sd0, 1'b1);
        chk("overflow_flag", longint'(xq_overflow), 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, prodf(10 * i + 1), 1'b1);
        idle(1'b1);

        // Reset with samples in flight, then a clean sample.
        cyc(1'b1, 50, 1'b0, 128'sd0, 1'b0);
        cyc(1'b1, 60, 1'b1, prodf(50), 1'b0);
        cyc(1'b1, 70, 1'b1, prodf(60), 1'b0);
        do_reset("rst_mid");
        idle(1'b1);
        one_sample(128, prodf(128), 84, "post_rst");
        chk("post_rst_flags", longint'({xq_overflow, xq_underflow, oq_overflow}), 0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
